// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one combinational lookup ROM between
// two burst-read requesters. A burst is a start address plus len+1 words. The
// ROM is walked one word per cycle, and registered read data goes back to the
// requester that owns the burst.
//
// Optional build feature: define MEMORY_ARBITER_STATS_EN to add the saturating
// per-requester grant counters grant_cnt0/grant_cnt1.
//
// Handshake: reqN_ready is high only in a cycle where the arbiter is IDLE and
// requester N wins arbitration. The request is accepted on the rising edge that
// ends a cycle in which reqN_valid and reqN_ready are both high. Responses have
// no backpressure.
module memory_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int LW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [LW-1:0] req0_len,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [LW-1:0] req1_len,
  output logic          req1_ready,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          resp_valid0,
  output logic          resp_valid1,
  output logic [DW-1:0] resp_data,
  output logic          resp_last,
  output logic          busy
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output logic [7:0]    grant_cnt0,
  output logic [7:0]    grant_cnt1
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;          // tie-break winner: 0 -> req0, 1 -> req1
  logic          owner_q, owner_d;    // requester owning the current burst
  logic [LW-1:0] cnt_q, cnt_d;        // words remaining after the current one
  logic [AW-1:0] addr_q, addr_d;      // doubles as mem_addr (held in IDLE)
  logic [DW-1:0] rdata_q, rdata_d;
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;
  logic          last_q, last_d;

  logic winner;
  logic accept;

  // Arbitration: a lone request wins outright; on a tie rr_q chooses.
  always_comb begin
    winner     = (req0_valid & req1_valid) ? rr_q : req1_valid;
    accept     = (state_q == S_IDLE) & (req0_valid | req1_valid);
    req0_ready = accept & ~winner;
    req1_ready = accept & winner;
  end

  // Next-state and response logic for the IDLE/BURST sequencer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    v0_d    = 1'b0;
    v1_d    = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = winner ? req1_addr : req0_addr;
          cnt_d   = winner ? req1_len : req0_len;
          owner_d = winner;
          rr_d    = ~winner;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        rdata_d = mem_rdata;
        v0_d    = ~owner_q;
        v1_d    = owner_q;
        last_d  = (cnt_q == '0);
        if (cnt_q == '0) begin
          // Keep the final address on mem_addr while idle.
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
          cnt_d  = cnt_q - {{(LW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset that aborts any burst.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      last_q  <= last_d;
    end
  end

  assign mem_addr    = addr_q;
  assign resp_data   = rdata_q;
  assign resp_valid0 = v0_q;
  assign resp_valid1 = v1_q;
  assign resp_last   = last_q;
  assign busy        = (state_q == S_BURST);

`ifdef MEMORY_ARBITER_STATS_EN
  logic [7:0] gc0_q, gc1_q;

  // Grant counters saturate at 255 and clear on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gc0_q <= '0;
      gc1_q <= '0;
    end else begin
      if (req0_ready && gc0_q != 8'hFF) gc0_q <= gc0_q + 8'd1;
      if (req1_ready && gc1_q != 8'hFF) gc1_q <= gc1_q + 8'd1;
    end
  end

  assign grant_cnt0 = gc0_q;
  assign grant_cnt1 = gc1_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: ROM model returns addr*10; a transaction-level
// reference turns each accepted request into a queue of expected response beats.
module tb_memory_arbiter;

  logic       clock;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_addr, req1_addr;
  logic [1:0] req0_len, req1_len;
  logic       req0_ready, req1_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       resp_valid0, resp_valid1, resp_last, busy;
  logic [7:0] resp_data;
`ifdef MEMORY_ARBITER_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  memory_arbiter #(.AW(4), .DW(8), .LW(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_data(resp_data), .resp_last(resp_last), .busy(busy)
`ifdef MEMORY_ARBITER_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Combinational lookup ROM: data = addr*10.
  assign mem_rdata = 8'(mem_addr * 10);

  // Clock / reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: one entry per future cycle, {valid0, valid1, last, data}.
  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rr_m;           // who wins a tie next
  int          g0_m, g1_m;     // model grant counts (saturating)
  logic        acc0, acc1;     // acceptance seen in the last step

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs, check readies,
  // and advance the reference model.
  task automatic step(input logic rst, input logic v0, input logic [3:0] a0, input logic [1:0] l0,
                      input logic v1, input logic [3:0] a1, input logic [1:0] l1);
    logic [10:0] beat;
    logic        idle_m, w, any;
    logic [3:0]  ad;
    @(negedge clock);
    beat = (exp_q.size() != 0) ? exp_q.pop_front() : 11'd0;
    check_eq("resp_valid0", 32'(resp_valid0), 32'(beat[10]));
    check_eq("resp_valid1", 32'(resp_valid1), 32'(beat[9]));
    check_eq("resp_last", 32'(resp_last), 32'(beat[8]));
    if (beat[10] | beat[9]) check_eq("resp_data", 32'(resp_data), 32'(beat[7:0]));
    idle_m = (exp_q.size() == 0);
    check_eq("busy", 32'(busy), 32'(!idle_m));
`ifdef MEMORY_ARBITER_STATS_EN
    check_eq("grant_cnt0", 32'(grant_cnt0), 32'(g0_m));
    check_eq("grant_cnt1", 32'(grant_cnt1), 32'(g1_m));
`endif
    reset = rst;
    req0_valid = v0; req0_addr = a0; req0_len = l0;
    req1_valid = v1; req1_addr = a1; req1_len = l1;
    #1;
    any = v0 | v1;
    w   = (v0 && v1) ? rr_m : v1;
    acc0 = idle_m & any & ~w;
    acc1 = idle_m & any & w;
    check_eq("req0_ready", 32'(req0_ready), 32'(acc0));
    check_eq("req1_ready", 32'(req1_ready), 32'(acc1));
    if (!rst) begin
      exp_q.delete();
      rr_m = 1'b0; g0_m = 0; g1_m = 0;
      acc0 = 1'b0; acc1 = 1'b0;
    end else if (acc0 | acc1) begin
      exp_q.push_back(11'd0);  // pipeline bubble before the first word
      for (int i = 0; i <= int'(w ? l1 : l0); i++) begin
        ad = (w ? a1 : a0) + 4'(i);
        exp_q.push_back({~w, w, (i == int'(w ? l1 : l0)), 8'(int'(ad) * 10)});
      end
      rr_m = ~w;
      if (w) g1_m = (g1_m < 255) ? g1_m + 1 : 255;
      else   g0_m = (g0_m < 255) ? g0_m + 1 : 255;
    end
  endtask

  // Driver: hold each request until it is accepted, for n cycles.
  task automatic run_held(input logic v0, input logic [3:0] a0, input logic [1:0] l0,
                          input logic v1, input logic [3:0] a1, input logic [1:0] l1, input int n);
    logic p0, p1;
    p0 = v0; p1 = v1;
    for (int c = 0; c < n; c++) begin
      step(1'b1, p0, a0, l0, p1, a1, l1);
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic       p0, p1;
    logic [3:0] ra0, ra1;
    logic [1:0] rl0, rl1;
    rr_m = 1'b0; g0_m = 0; g1_m = 0; acc0 = 0; acc1 = 0;
    reset = 1'b0;
    req0_valid = 0; req0_addr = 0; req0_len = 0;
    req1_valid = 0; req1_addr = 0; req1_len = 0;

    // Reset state.
    do_reset();
    idle(1);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_resp_data", 32'(resp_data), 32'd0);

    // Lone req0 burst: 30, 40, 50.
    run_held(1, 4'd3, 2'd2, 0, 0, 0, 1);
    idle(6);
    // req1 burst across the address wrap: 140, 150, 0, 10.
    run_held(0, 0, 0, 1, 4'd14, 2'd3, 1);
    idle(7);

    // Tie from reset: req0 first, then req1; repeat to show alternation.
    do_reset();
    run_held(1, 4'd1, 2'd0, 1, 4'd2, 2'd0, 8);
    run_held(1, 4'd1, 2'd0, 1, 4'd2, 2'd0, 8);
    idle(2);

    // req1 arrives during a req0 burst and stays pending until IDLE.
    run_held(1, 4'd5, 2'd3, 0, 0, 0, 2);
    run_held(0, 0, 0, 1, 4'd7, 2'd1, 10);
    idle(2);

    // Reset during the second word of a len=3 burst.
    run_held(1, 4'd8, 2'd3, 0, 0, 0, 1);
    idle(2);                              // bubble, first word
    step(1'b0, 0, 0, 0, 0, 0, 0);         // second word on the outputs
    idle(1);
    check_eq("abort_resp_data", 32'(resp_data), 32'd0);
    check_eq("abort_mem_addr", 32'(mem_addr), 32'd0);
    idle(5);

    // Randomized traffic with held requests.
    p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rl0 = 0; rl1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; ra0 = 4'($urandom_range(0, 15)); rl0 = 2'($urandom_range(0, 3));
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; ra1 = 4'($urandom_range(0, 15)); rl1 = 2'($urandom_range(0, 3));
      end
      step(1'b1, p0, ra0, rl0, p1, ra1, rl1);
      if (acc0) p0 = 0;
      if (acc1) p1 = 0;
    end
    idle(8);
    check_eq("drain", 32'(exp_q.size()), 32'd0);

`ifdef MEMORY_ARBITER_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) run_held(1, 4'(i), 2'd0, 0, 0, 0, 3);
    for (int i = 0; i < 2; i++) run_held(0, 0, 0, 1, 4'(i), 2'd0, 3);
    idle(1);
    check_eq("stats_cnt0_3", 32'(grant_cnt0), 32'd3);
    check_eq("stats_cnt1_2", 32'(grant_cnt1), 32'd2);
    for (int i = 0; i < 300; i++) run_held(1, 4'(i), 2'd0, 0, 0, 0, 3);
    idle(1);
    check_eq("stats_cnt0_sat", 32'(grant_cnt0), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
